alt_vipvfr131_common_frame_sequencer: RTL and testbench
=======================================================

// Module: alt_vipvfr131_common_frame_sequencer
// PURPOSE
//  Frame-level controller for the VIP stall/read/write flow-control interface.
//  - Sits between the flow-control wrapper's algorithm-side ports and the wrapper's output side.
//  - Per frame: latches the frame format, emits one control-packet request, then moves exactly
//    width*height beats from input to output.
//  - Output data passes through a 2-entry skid buffer; the frame terminates with end_of_video_out.
// PARAMETERS
//  BITS_PER_SYMBOL   8  bits per colour symbol
//  SYMBOLS_PER_BEAT  3  symbols per beat; DW = BITS_PER_SYMBOL*SYMBOLS_PER_BEAT
// PORTS
//  clk                 in   1   single clock
//  rst                 in   1   asynchronous reset, active high
//  stall_in            in   1   1 = no input beat available this cycle
//  data_in             in   DW  input beat; valid when ~stall_in
//  width_in            in   16  decoded frame width
//  height_in           in   16  decoded frame height
//  interlaced_in       in   4   decoded interlace flags
//  vip_ctrl_valid_in   in   1   1-cycle strobe: width/height/interlaced_in valid
//  end_of_video_in     in   1   qualifies the beat read this cycle as the last input beat
//  stall_out           in   1   1 = downstream cannot accept a beat
//  read                out  1   input beat consumed this cycle
//  write               out  1   output beat presented and accepted this cycle
//  data_out            out  DW  output beat; valid when write
//  width_out           out  16  frame width sent to the encoder
//  height_out          out  16  frame height sent to the encoder
//  interlaced_out      out  4   interlace flags sent to the encoder
//  vip_ctrl_valid_out  out  1   1-cycle control-packet request
//  end_of_video_out    out  1   high together with write on the final beat of the frame
//  frame_busy          out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset values
//   - read=0, write=0, vip_ctrl_valid_out=0, end_of_video_out=0, frame_busy=0, data_out=0.
//   - width_out=640, height_out=480, interlaced_out=0.
//   - Shadow format registers = 640/480/0; buffer empty; counters 0; state IDLE.
//  Shadow format registers
//   - Loaded on any cycle with vip_ctrl_valid_in, in any state.
//   - Copied to the *_out registers only on IDLE->SEND_CTRL, so a mid-frame update applies to the next frame.
//   - A strobe coincident with the IDLE->SEND_CTRL transition is used for that frame
//     (the shadow register bypasses to the *_out registers).
//  FSM
//   - IDLE -> SEND_CTRL when ~stall_in.
//   - SEND_CTRL: vip_ctrl_valid_out=1 for exactly 1 cycle.
//     -> DONE if the latched width==0 or height==0; else -> ACTIVE.
//   - ACTIVE: read = ~stall_in & (fill<2) & ~last_read.
//     - x counts 0..width-1; y increments when x wraps.
//     - last_read is set when a beat is read with (x==width-1 & y==height-1), or with end_of_video_in.
//     - -> FLUSH on that beat.
//   - FLUSH: read=0; drain the buffer; -> DONE when the write with end_of_video_out completes.
//   - DONE: 1 cycle, clears counters -> IDLE. Frame timing: SEND_CTRL/FLUSH/DONE each add fixed cycles.
//  Buffer
//   - Beat read in cycle N is writable in N+1 (latency 1); write = (fill>0) & ~stall_out.
//   - Simultaneous read and write keeps fill unchanged.
//   - Full (fill==2) blocks read; empty blocks write.
//   - Full throughput: 1 beat/cycle when there is no stall.
//   - end_of_video_out marks the buffered beat tagged last.
//  Reset mid-frame aborts immediately: buffer contents are discarded and no end_of_video_out is issued.
// CONFIGURATION
//  ALT_VIPVFR131_FRAME_COUNTER_EN defined:
//   - Adds output frame_count[15:0] (reset 0).
//   - Increments in DONE and wraps 0xFFFF->0.
//  Undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE, SEND_CTRL, ACTIVE, FLUSH, DONE),
//  reset defaults (640/480/0), buffer depth 2.
//  One sub-module: alt_vipvfr131_common_skid_buffer, a 2-entry DW+1 bit FIFO
//  (data + last tag) with fill count.
// TESTING
//  1. 4x2 frame, no stalls -> vip_ctrl_valid_out 1 pulse with 4/2; 8 writes on consecutive
//     cycles; end_of_video_out on write #8 only.
//  2. Same frame, stall_out high for 3 cycles mid-frame -> read stops after fill==2;
//     no beat lost or duplicated; data order preserved.
//  3. Frame 4x4, end_of_video_in on beat 5 -> exactly 5 writes; end_of_video_out on write 5; return to IDLE.
//  4. width_in=0 strobe, then ~stall_in -> ctrl pulse with width_out=0; no read/write; DONE -> IDLE.
//  5. vip_ctrl_valid_in 8x1 during an ACTIVE 4x2 frame -> current frame is 8 beats;
//     next frame's ctrl pulse reports 8/1.
//  6. rst asserted after beat 3 of 4x2 -> all outputs at reset values next edge;
//     the next frame restarts with SEND_CTRL.

Source files
------------

// File: rtl/alt_vipvfr131_common_frame_sequencer_pkg.sv
// Shared types and constants for the VIP frame sequencer and its skid buffer.
package alt_vipvfr131_common_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSendCtrl = 3'd1,
    StActive   = 3'd2,
    StFlush    = 3'd3,
    StDone     = 3'd4
  } seq_state_e;

  localparam logic [15:0] DefaultWidth      = 16'd640;
  localparam logic [15:0] DefaultHeight     = 16'd480;
  localparam logic [3:0]  DefaultInterlaced = 4'd0;
  localparam int unsigned BufDepth          = 2;

  function automatic logic is_last_pos(input logic [15:0] x, input logic [15:0] y,
                                       input logic [15:0] w, input logic [15:0] h);
    return (x == w - 16'd1) && (y == h - 16'd1);
  endfunction

endpackage

// File: rtl/alt_vipvfr131_common_skid_buffer.sv
// Two-entry FIFO carrying an output beat plus its end-of-frame tag.
module alt_vipvfr131_common_skid_buffer
  import alt_vipvfr131_common_frame_sequencer_pkg::*;
#(
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic [1:0]    fill
);

  logic [DW:0] mem_q [BufDepth];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  fill_q;
  logic        do_push, do_pop;

  assign do_push = push && (fill_q != 2'd2);
  assign do_pop  = pop && (fill_q != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BufDepth; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= {push_last, push_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      if (do_push && !do_pop)      fill_q <= fill_q + 2'd1;
      else if (!do_push && do_pop) fill_q <= fill_q - 2'd1;
    end
  end

  assign head_data = mem_q[rd_ptr_q][DW-1:0];
  assign head_last = mem_q[rd_ptr_q][DW];
  assign fill      = fill_q;

endmodule

// File: rtl/alt_vipvfr131_common_frame_sequencer.sv
// Per-frame controller: latch format, request a control packet, move width*height beats.
// Optional ALT_VIPVFR131_FRAME_COUNTER_EN adds a wrapping frame_count output.
module alt_vipvfr131_common_frame_sequencer
  import alt_vipvfr131_common_frame_sequencer_pkg::*;
#(
  parameter int unsigned BITS_PER_SYMBOL  = 8,
  parameter int unsigned SYMBOLS_PER_BEAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        stall_in,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_in,
  input  logic [15:0]                                 width_in,
  input  logic [15:0]                                 height_in,
  input  logic [3:0]                                  interlaced_in,
  input  logic                                        vip_ctrl_valid_in,
  input  logic                                        end_of_video_in,
  input  logic                                        stall_out,
  output logic                                        read,
  output logic                                        write,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
  output logic [15:0]                                 width_out,
  output logic [15:0]                                 height_out,
  output logic [3:0]                                  interlaced_out,
  output logic                                        vip_ctrl_valid_out,
  output logic                                        end_of_video_out,
`ifdef ALT_VIPVFR131_FRAME_COUNTER_EN
  output logic [15:0]                                 frame_count,
`endif
  output logic                                        frame_busy
);

  localparam int unsigned DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;

  seq_state_e  state_q, state_d;
  logic [15:0] shadow_w_q, shadow_h_q;
  logic [3:0]  shadow_i_q;
  logic [15:0] width_q, height_q;
  logic [3:0]  interlaced_q;
  logic [15:0] x_q, y_q;
  logic        last_read_q;
  logic        load_fmt, clr_cnt, last_beat;
  logic        head_last;
  logic [1:0]  fill;

  assign last_beat = is_last_pos(x_q, y_q, width_q, height_q) || end_of_video_in;
  assign write     = (fill != 2'd0) && !stall_out;
  assign end_of_video_out = write && head_last;

  always_comb begin
    state_d            = state_q;
    read               = 1'b0;
    vip_ctrl_valid_out = 1'b0;
    load_fmt           = 1'b0;
    clr_cnt            = 1'b0;
    case (state_q)
      StIdle: begin
        if (!stall_in) begin
          state_d  = StSendCtrl;
          load_fmt = 1'b1;
        end
      end
      StSendCtrl: begin
        vip_ctrl_valid_out = 1'b1;
        state_d = (width_q == 16'd0 || height_q == 16'd0) ? StDone : StActive;
      end
      StActive: begin
        read = !stall_in && (fill != 2'd2) && !last_read_q;
        if (read && last_beat) state_d = StFlush;
      end
      StFlush: begin
        if (end_of_video_out) state_d = StDone;
      end
      StDone: begin
        clr_cnt = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      shadow_w_q   <= DefaultWidth;
      shadow_h_q   <= DefaultHeight;
      shadow_i_q   <= DefaultInterlaced;
      width_q      <= DefaultWidth;
      height_q     <= DefaultHeight;
      interlaced_q <= DefaultInterlaced;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      last_read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (vip_ctrl_valid_in) begin
        shadow_w_q <= width_in;
        shadow_h_q <= height_in;
        shadow_i_q <= interlaced_in;
      end
      // A strobe landing on the start cycle belongs to the frame being started.
      if (load_fmt) begin
        width_q      <= vip_ctrl_valid_in ? width_in      : shadow_w_q;
        height_q     <= vip_ctrl_valid_in ? height_in     : shadow_h_q;
        interlaced_q <= vip_ctrl_valid_in ? interlaced_in : shadow_i_q;
      end
      if (clr_cnt) begin
        x_q         <= 16'd0;
        y_q         <= 16'd0;
        last_read_q <= 1'b0;
      end else if (read) begin
        if (x_q == width_q - 16'd1) begin
          x_q <= 16'd0;
          y_q <= y_q + 16'd1;
        end else begin
          x_q <= x_q + 16'd1;
        end
        if (last_beat) last_read_q <= 1'b1;
      end
    end
  end

`ifdef ALT_VIPVFR131_FRAME_COUNTER_EN
  logic [15:0] frame_count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     frame_count_q <= 16'd0;
    else if (state_q == StDone)  frame_count_q <= frame_count_q + 16'd1;
  end
  assign frame_count = frame_count_q;
`endif

  alt_vipvfr131_common_skid_buffer #(
    .DW(DW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (read),
    .push_data (data_in),
    .push_last (last_beat),
    .pop       (write),
    .head_data (data_out),
    .head_last (head_last),
    .fill      (fill)
  );

  assign width_out      = width_q;
  assign height_out     = height_q;
  assign interlaced_out = interlaced_q;
  assign frame_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alt_vipvfr131_common_frame_sequencer.sv
// Directed bench for the frame sequencer: frame shape, backpressure, early end, resets.
module tb_alt_vipvfr131_common_frame_sequencer;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst, stall_in, vip_ctrl_valid_in, end_of_video_in, stall_out;
  logic [DW-1:0] data_in, data_out;
  logic [15:0]   width_in, height_in, width_out, height_out;
  logic [3:0]    interlaced_in, interlaced_out;
  logic          read, write, vip_ctrl_valid_out, end_of_video_out, frame_busy;
`ifdef ALT_VIPVFR131_FRAME_COUNTER_EN
  logic [15:0]   frame_count;
`endif

  alt_vipvfr131_common_frame_sequencer #(
    .BITS_PER_SYMBOL (8),
    .SYMBOLS_PER_BEAT(3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_in          (stall_in),
    .data_in           (data_in),
    .width_in          (width_in),
    .height_in         (height_in),
    .interlaced_in     (interlaced_in),
    .vip_ctrl_valid_in (vip_ctrl_valid_in),
    .end_of_video_in   (end_of_video_in),
    .stall_out         (stall_out),
    .read              (read),
    .write             (write),
    .data_out          (data_out),
    .width_out         (width_out),
    .height_out        (height_out),
    .interlaced_out    (interlaced_out),
    .vip_ctrl_valid_out(vip_ctrl_valid_out),
    .end_of_video_out  (end_of_video_out),
`ifdef ALT_VIPVFR131_FRAME_COUNTER_EN
    .frame_count       (frame_count),
`endif
    .frame_busy        (frame_busy)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  int            reads, rd_in_stall, ctrl_cnt, src, eov_at;
  logic [15:0]   ctrl_w, ctrl_h;
  logic [DW-1:0] base;
  logic [DW-1:0] wr_data[$];
  logic          wr_eov[$];
  int            wr_cyc[$];
  logic          fin, aborted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " read"}, 32'(read), 0);
    chk({tag, " write"}, 32'(write), 0);
    chk({tag, " ctrl"}, 32'(vip_ctrl_valid_out), 0);
    chk({tag, " eov"}, 32'(end_of_video_out), 0);
    chk({tag, " busy"}, 32'(frame_busy), 0);
    chk({tag, " data_out"}, 32'(data_out), 0);
    chk({tag, " width_out"}, 32'(width_out), 640);
    chk({tag, " height_out"}, 32'(height_out), 480);
    chk({tag, " interlaced_out"}, 32'(interlaced_out), 0);
  endtask

  task automatic strobe(input logic [15:0] w, input logic [15:0] h);
    width_in = w;
    height_in = h;
    vip_ctrl_valid_in = 1'b1;
    @(posedge clk);
    #1;
    vip_ctrl_valid_in = 1'b0;
  endtask

  // Drives one frame from IDLE; r counts cycles since stall_in dropped.
  task automatic run(input int bound, input int stall_from, input int stall_len,
                     input int strobe_at, input logic [15:0] sw, input logic [15:0] sh,
                     input int rst_after);
    reads = 0; rd_in_stall = 0; ctrl_cnt = 0; src = 0;
    ctrl_w = 16'hdead; ctrl_h = 16'hdead;
    wr_data.delete(); wr_eov.delete(); wr_cyc.delete();
    fin = 1'b0; aborted = 1'b0;
    data_in = base;
    end_of_video_in = (eov_at == 1);
    stall_in = 1'b0;
    begin
      logic saw;
      saw = 1'b0;
      for (int r = 0; r < bound && !fin; r++) begin
        stall_out = (r >= stall_from) && (r < stall_from + stall_len);
        if (r == strobe_at) begin
          width_in = sw; height_in = sh; vip_ctrl_valid_in = 1'b1;
        end else begin
          vip_ctrl_valid_in = 1'b0;
        end
        @(negedge clk);
        if (frame_busy) saw = 1'b1;
        if (write) begin
          wr_data.push_back(data_out);
          wr_eov.push_back(end_of_video_out);
          wr_cyc.push_back(r);
        end
        if (read) begin
          reads++;
          src++;
          if (stall_out) rd_in_stall++;
        end
        if (vip_ctrl_valid_out) begin
          ctrl_cnt++; ctrl_w = width_out; ctrl_h = height_out;
        end
        if (rst_after != 0 && reads == rst_after) begin
          rst = 1'b1; aborted = 1'b1; fin = 1'b1;
        end else if (saw && !frame_busy) begin
          stall_in = 1'b1; fin = 1'b1;
        end
        @(posedge clk);
        #1;
        data_in = base + DW'(src);
        end_of_video_in = (eov_at != 0) && (src + 1 == eov_at);
      end
    end
    vip_ctrl_valid_in = 1'b0;
    stall_out = 1'b0;
    end_of_video_in = 1'b0;
    chk("frame completed within bound", 32'(fin), 1);
  endtask

  task automatic check_frame(input string tag, input int n);
    int errs, eovs;
    logic last_eov;
    errs = 0; eovs = 0;
    foreach (wr_data[i]) if (wr_data[i] !== base + DW'(i)) errs++;
    foreach (wr_eov[i]) if (wr_eov[i]) eovs++;
    last_eov = (wr_eov.size() > 0) ? wr_eov[wr_eov.size()-1] : 1'b0;
    chk({tag, " writes"}, 32'(wr_data.size()), 32'(n));
    chk({tag, " order"}, 32'(errs), 0);
    chk({tag, " eov count"}, 32'(eovs), 1);
    chk({tag, " eov on last"}, 32'(last_eov), 1);
  endtask

  initial begin
    rst = 1'b0; stall_in = 1'b1; stall_out = 1'b0; vip_ctrl_valid_in = 1'b0;
    end_of_video_in = 1'b0; data_in = '0; width_in = '0; height_in = '0;
    interlaced_in = '0; eov_at = 0; base = '0;
    #2 rst = 1'b1;
    #1 check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 4x2 frame, no backpressure
    strobe(16'd4, 16'd2);
    base = 24'h100000;
    run(60, -10, 0, -1, 16'd0, 16'd0, 0);
    chk("t1 ctrl pulses", 32'(ctrl_cnt), 1);
    chk("t1 ctrl width", 32'(ctrl_w), 4);
    chk("t1 ctrl height", 32'(ctrl_h), 2);
    check_frame("t1", 8);
    chk("t1 back-to-back writes",
        32'((wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] - wr_cyc[0] : -1), 7);

    // Same frame with 3 cycles of downstream stall starting on the third read
    base = 24'h200000;
    run(60, 4, 3, -1, 16'd0, 16'd0, 0);
    chk("t2 reads while stalled", 32'(rd_in_stall), 1);
    chk("t2 ctrl width", 32'(ctrl_w), 4);
    check_frame("t2", 8);

    // 4x4 frame cut short by end_of_video_in on beat 5
    strobe(16'd4, 16'd4);
    base = 24'h300000;
    eov_at = 5;
    run(60, -10, 0, -1, 16'd0, 16'd0, 0);
    eov_at = 0;
    chk("t3 reads", 32'(reads), 5);
    check_frame("t3", 5);

    // Zero-width frame
    strobe(16'd0, 16'd5);
    base = 24'h400000;
    run(30, -10, 0, -1, 16'd0, 16'd0, 0);
    chk("t4 ctrl pulses", 32'(ctrl_cnt), 1);
    chk("t4 ctrl width", 32'(ctrl_w), 0);
    chk("t4 reads", 32'(reads), 0);
    chk("t4 writes", 32'(wr_data.size()), 0);

    // Mid-frame format update applies only to the following frame
    strobe(16'd4, 16'd2);
    base = 24'h500000;
    run(60, -10, 0, 4, 16'd8, 16'd1, 0);
    chk("t5a ctrl width", 32'(ctrl_w), 4);
    chk("t5a ctrl height", 32'(ctrl_h), 2);
    check_frame("t5a", 8);
    base = 24'h580000;
    run(60, -10, 0, -1, 16'd0, 16'd0, 0);
    chk("t5b ctrl width", 32'(ctrl_w), 8);
    chk("t5b ctrl height", 32'(ctrl_h), 1);
    check_frame("t5b", 8);

    // Reset after the third beat is read
    strobe(16'd4, 16'd2);
    base = 24'h600000;
    run(60, -10, 0, -1, 16'd0, 16'd0, 3);
    chk("t6 aborted", 32'(aborted), 1);
    chk("t6 writes before abort", 32'(wr_data.size()), 2);
    chk("t6 no eov before abort", 32'((wr_eov.size() > 1) ? (wr_eov[0] | wr_eov[1]) : 1'b1), 0);
    stall_in = 1'b1;
    check_reset("t6 abort");
    rst = 1'b0;
    @(posedge clk); #1;
    strobe(16'd4, 16'd2);
    base = 24'h700000;
    run(60, -10, 0, -1, 16'd0, 16'd0, 0);
    chk("t6 restart ctrl pulses", 32'(ctrl_cnt), 1);
    chk("t6 restart ctrl width", 32'(ctrl_w), 4);
    check_frame("t6 restart", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
